// File: rtl/val_rdy_skid_queue.sv
// Two-entry val/rdy queue with fully registered outputs, used as a skid buffer
// between pipeline stages; sustains one message per cycle under continuous flow.
module val_rdy_skid_queue #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg,
    output logic [1:0]         num_free_entries
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    logic [p_nbits-1:0] head;
    logic [p_nbits-1:0] tail;
    logic               enq_fire;
    logic               deq_fire;

    // Handshake outputs come only from the state register, never from the other side's inputs.
    assign enq_rdy          = (state != TWO) && !reset;
    assign deq_val          = (state != EMPTY) && !reset;
    assign deq_msg          = head;
    assign num_free_entries = reset ? 2'd2 : (2'd2 - 2'(state));

    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (enq_fire) state <= ONE;
                ONE: begin
                    if (enq_fire && !deq_fire)
                        state <= TWO;
                    else if (!enq_fire && deq_fire)
                        state <= EMPTY;
                end
                TWO:     if (deq_fire) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // Head always holds the oldest message; tail only ever holds the second one.
    always_ff @(posedge clk) begin
        if (enq_fire && ((state == EMPTY) || ((state == ONE) && deq_fire)))
            head <= enq_msg;
        else if ((state == TWO) && deq_fire)
            head <= tail;

        if (enq_fire && (state == ONE) && !deq_fire)
            tail <= enq_msg;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(enq_val));
            assert (!$isunknown(deq_rdy));
            assert (2'(state) != 2'd3);
        end
    end
`endif

endmodule

// File: tb/tb_val_rdy_skid_queue.sv
// Directed and randomly backpressured checks of the two-entry val/rdy queue,
// comparing handshake outputs and message order against hand-computed values.
module tb_val_rdy_skid_queue;

    logic        clk;
    logic        reset;
    logic        enq_val;
    logic        enq_rdy;
    logic [31:0] enq_msg;
    logic        deq_val;
    logic        deq_rdy;
    logic [31:0] deq_msg;
    logic [1:0]  num_free_entries;

    int checks = 0;
    int errors = 0;

    logic [31:0] msgs [100];
    logic [31:0] model_q [$];
    int          sent;
    int          received;
    int          cycles;
    logic        enq_fire;
    logic        deq_fire;

    val_rdy_skid_queue #(.p_nbits(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .enq_val          (enq_val),
        .enq_rdy          (enq_rdy),
        .enq_msg          (enq_msg),
        .deq_val          (deq_val),
        .deq_rdy          (deq_rdy),
        .deq_msg          (deq_msg),
        .num_free_entries (num_free_entries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after an edge; outputs settle before they are sampled.
    task automatic applyStimulus(input logic ev, input logic [31:0] msg, input logic dr);
        enq_val = ev;
        enq_msg = msg;
        deq_rdy = dr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst_enq_rdy", 32'(enq_rdy), 32'd0);
        checkOutput("rst_deq_val", 32'(deq_val), 32'd0);
        checkOutput("rst_nfree", 32'(num_free_entries), 32'd2);

        reset = 1'b0;
        #1;
        checkOutput("post_rst_enq_rdy", 32'(enq_rdy), 32'd1);
        checkOutput("post_rst_deq_val", 32'(deq_val), 32'd0);
        checkOutput("post_rst_nfree", 32'(num_free_entries), 32'd2);

        // Single message
        applyStimulus(1'b1, 32'h0000_00AB, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("single_deq_val", 32'(deq_val), 32'd1);
        checkOutput("single_deq_msg", deq_msg, 32'h0000_00AB);
        checkOutput("single_nfree", 32'(num_free_entries), 32'd1);
        checkOutput("single_enq_rdy", 32'(enq_rdy), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("single_drained", 32'(deq_val), 32'd0);
        checkOutput("single_drained_nfree", 32'(num_free_entries), 32'd2);

        // Fill to full, offer a third message that must be refused
        applyStimulus(1'b1, 32'h11, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h22, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h33, 1'b0);
        checkOutput("full_enq_rdy", 32'(enq_rdy), 32'd0);
        checkOutput("full_nfree", 32'(num_free_entries), 32'd0);
        checkOutput("full_head", deq_msg, 32'h11);
        tick();
        checkOutput("full_hold_nfree", 32'(num_free_entries), 32'd0);
        checkOutput("full_hold_head", deq_msg, 32'h11);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("drain1_val", 32'(deq_val), 32'd1);
        checkOutput("drain1_msg", deq_msg, 32'h22);
        checkOutput("drain1_enq_rdy", 32'(enq_rdy), 32'd1);
        checkOutput("drain1_nfree", 32'(num_free_entries), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("drain2_val", 32'(deq_val), 32'd0);
        checkOutput("drain2_enq_rdy", 32'(enq_rdy), 32'd1);

        // Streaming with the consumer always ready
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b1);
            checkOutput("stream_enq_rdy", 32'(enq_rdy), 32'd1);
            tick();
            checkOutput("stream_deq_val", 32'(deq_val), 32'd1);
            checkOutput("stream_deq_msg", deq_msg, 32'(i));
            checkOutput("stream_nfree", 32'(num_free_entries), 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("stream_end_val", 32'(deq_val), 32'd0);

        // Random backpressure against a FIFO model
        for (int i = 0; i < 100; i++) msgs[i] = $urandom;
        sent = 0;
        received = 0;
        cycles = 0;
        while (received < 100 && cycles < 5000) begin
            applyStimulus((sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0,
                          (sent < 100) ? msgs[sent] : 32'h0,
                          1'($urandom_range(0, 1)));
            checkOutput("rand_deq_val", 32'(deq_val), 32'(model_q.size() != 0));
            checkOutput("rand_enq_rdy", 32'(enq_rdy), 32'(model_q.size() < 2));
            enq_fire = enq_val && enq_rdy;
            deq_fire = deq_val && deq_rdy;
            if (deq_val)
                checkOutput("rand_msg_known", 32'($isunknown(deq_msg)), 32'd0);
            if (deq_fire && model_q.size() != 0) begin
                checkOutput("rand_order", deq_msg, model_q[0]);
                void'(model_q.pop_front());
                received++;
            end
            if (enq_fire) begin
                model_q.push_back(msgs[sent]);
                sent++;
            end
            tick();
            cycles++;
        end
        checkOutput("rand_received", 32'(received), 32'd100);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Reset while full with a message offered concurrently
        applyStimulus(1'b1, 32'h5, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h6, 1'b0);
        tick();
        checkOutput("pre_rst_nfree", 32'(num_free_entries), 32'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h77, 1'b1);
        checkOutput("mid_rst_enq_rdy", 32'(enq_rdy), 32'd0);
        checkOutput("mid_rst_deq_val", 32'(deq_val), 32'd0);
        checkOutput("mid_rst_nfree", 32'(num_free_entries), 32'd2);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("after_rst_deq_val", 32'(deq_val), 32'd0);
        checkOutput("after_rst_nfree", 32'(num_free_entries), 32'd2);
        checkOutput("after_rst_enq_rdy", 32'(enq_rdy), 32'd1);
        tick();
        checkOutput("after_rst_still_empty", 32'(deq_val), 32'd0);
        applyStimulus(1'b1, 32'h99, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("after_rst_new_val", 32'(deq_val), 32'd1);
        checkOutput("after_rst_new_msg", deq_msg, 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/val_rdy_skid_queue.md
Name: val_rdy_skid_queue

Overview:
- Two-entry val/rdy FIFO queue (skid buffer) that decouples a producer (enq side) from a consumer (deq side).
- Acts as the storage element between pipeline stages of the iterative/pipelined multiplier datapaths and the test sources and sinks.
- Fully registered outputs: no combinational path from deq_rdy to enq_rdy, or from enq_val/enq_msg to deq_val/deq_msg.
- Sustains one message per cycle under continuous flow.

Parameters:
- p_nbits, 32, width of the message payload in bits

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- enq_val  input  1  producer has a valid message on enq_msg
- enq_rdy  output  1  queue can accept a message this cycle
- enq_msg  input  p_nbits  message payload from producer
- deq_val  output  1  queue head holds a valid message
- deq_rdy  input  1  consumer accepts the head message this cycle
- deq_msg  output  p_nbits  head message payload
- num_free_entries  output  2  free slots: 0, 1 or 2

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Transfers: enq fires when enq_val && enq_rdy at a posedge; deq fires when deq_val && deq_rdy at a posedge. Val never depends on rdy on either side.
- Storage:
  - Two p_nbits data registers, head and tail; data registers are not reset.
  - A 2-bit state register: EMPTY=0, ONE=1, TWO=2.
- Outputs are decoded from registered state only:
  - enq_rdy = (state != TWO) && !reset
  - deq_val = (state != EMPTY) && !reset
  - deq_msg = head
  - num_free_entries = 2 - state (reads 2 during reset)
- Reset values: state=EMPTY; while reset is high, enq_rdy=0 and deq_val=0. deq_msg is don't-care whenever deq_val=0. enq_rdy=1 in the first cycle after reset deasserts.
- Transitions:
  - EMPTY, enq -> ONE; head<=enq_msg.
  - ONE, enq only -> TWO; tail<=enq_msg.
  - ONE, deq only -> EMPTY.
  - ONE, enq and deq -> ONE; head<=enq_msg.
  - TWO, deq -> ONE; head<=tail. enq cannot fire because enq_rdy=0.
  - No fire -> hold all state.
- Latency: a message enqueued at edge k is first visible on deq_val/deq_msg in the cycle after edge k. There is no same-cycle bypass.
- Throughput: one message per cycle whenever deq_rdy is held at 1. state never reaches TWO in that case.
- Ordering: strict FIFO; no message is dropped or duplicated.
- Full boundary: in TWO, enq_val is ignored. The producer must hold enq_msg stable until enq_rdy returns.
- Empty boundary: in EMPTY, deq_rdy is ignored and the state is unchanged.
- Reset mid-operation: reset asserted in any state discards all contents; the next cycle is EMPTY regardless of enq_val/deq_rdy.
- Assertions (non-synthesis only, when !reset): enq_val and deq_rdy are not X; state never equals 3.

Test Plan:
- Reset then idle -> during reset enq_rdy=0, deq_val=0; first cycle after reset enq_rdy=1, deq_val=0, num_free_entries=2.
- Single message: enq 0x0000_00AB with deq_rdy=0 -> next cycle deq_val=1, deq_msg=0xAB, num_free_entries=1. Raise deq_rdy -> following cycle deq_val=0.
- Fill to full: enq 0x11, 0x22 with deq_rdy=0 -> enq_rdy=0, num_free_entries=0. Drive enq_val with 0x33 -> not accepted. Drain -> outputs 0x11, 0x22 in order, then enq_rdy=1.
- Streaming: enq 0x1..0x8 on consecutive cycles with deq_rdy=1 -> 8 deq fires on consecutive cycles, one cycle after each enq, values 0x1..0x8; enq_rdy stays 1.
- Random backpressure: 100 random 32-bit messages, random enq_val/deq_rdy (50%) -> output sequence equals input sequence; no X on deq_msg when deq_val=1.
- Reset mid-operation: queue in TWO holding 0x5,0x6; assert reset for one cycle with enq_val=1 -> next cycle deq_val=0, num_free_entries=2; 0x5, 0x6 and the concurrent message never appear on deq.
